// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequence counter.
// Holds the mode encodings and the home-state helper used by the counter
// and the legality checker.
package shift_seq_pkg;

  // Counter mode: twisted ring (period 2*W) or plain ring (period W).
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  // Home state for a mode, returned wide; callers truncate to their width.
  function automatic logic [31:0] home_state(input logic mode);
    return (mode == MODE_RING) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/shift_seq_legal.sv
// Legality checker for the shift sequence counter state.
// Ports:
//   cnt   - current counter state
//   mode  - MODE_JOHNSON or MODE_RING
//   legal - 1 when cnt is a state reachable in that mode (combinational)
// Only instantiated when SHIFT_SEQ_SELF_CORRECT_EN is defined.
module shift_seq_legal
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-1:0] inv;
  logic             low_run;
  logic             high_run;
  logic             one_hot;

  // Johnson states are a run of ones at the bottom (0..01..1) or at the top
  // (1..10..0); a ring state has exactly one bit set.
  always_comb begin
    inv      = ~cnt;
    low_run  = ((cnt & (cnt + WIDTH'(1))) == '0);
    high_run = ((inv & (inv + WIDTH'(1))) == '0);
    one_hot  = (cnt != '0) && ((cnt & (cnt - WIDTH'(1))) == '0);
    legal    = (mode == MODE_RING) ? one_hot : (low_run | high_run);
  end

endmodule

// File: rtl/shift_seq_counter.sv
// Johnson / ring shift counter with phase index and wrap pulse.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-high reset
//   en_i        - advance one step this cycle
//   dir_i       - 0 shift toward MSB (up), 1 toward LSB (down)
//   mode_i      - 0 Johnson, 1 ring; a change re-homes the counter
//   load_i      - synchronous parallel load of load_val_i
//   cnt_o       - registered counter state
//   phase_o     - step index within the period
//   wrap_o      - one-cycle pulse after a step landing on phase 0
// Build option: define SHIFT_SEQ_SELF_CORRECT_EN to re-home illegal states
// on a step instead of shifting them.
module shift_seq_counter
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          dir_i,
  input  logic                          mode_i,
  input  logic                          load_i,
  input  logic [WIDTH-1:0]              load_val_i,
  output logic [WIDTH-1:0]              cnt_o,
  output logic [$clog2(2*WIDTH)-1:0]    phase_o,
  output logic                          wrap_o
);

  localparam int unsigned PW = $clog2(2 * WIDTH);
  // Last phase index of each period (P-1); P itself may not fit in PW bits.
  localparam logic [PW-1:0] LAST_J = PW'(2 * WIDTH - 1);
  localparam logic [PW-1:0] LAST_R = PW'(WIDTH - 1);

  logic             mode_q;
  logic             mode_d;
  logic [WIDTH-1:0] cnt_d;
  logic [PW-1:0]    phase_d;
  logic             wrap_d;
  logic [PW-1:0]    last;
  logic             fb;
  logic             illegal_c;

`ifdef SHIFT_SEQ_SELF_CORRECT_EN
  logic legal;

  shift_seq_legal #(.WIDTH(WIDTH)) u_legal (
    .cnt   (cnt_o),
    .mode  (mode_q),
    .legal (legal)
  );

  assign illegal_c = ~legal;
`else
  assign illegal_c = 1'b0;
`endif

  // Next state: load > mode change > step > hold.
  always_comb begin
    cnt_d   = cnt_o;
    phase_d = phase_o;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    fb      = 1'b0;
    last    = (mode_q == MODE_RING) ? LAST_R : LAST_J;

    if (load_i) begin
      cnt_d   = load_val_i;
      phase_d = '0;
    end else if (mode_i != mode_q) begin
      mode_d  = mode_i;
      cnt_d   = WIDTH'(home_state(mode_i));
      phase_d = '0;
    end else if (en_i) begin
      if (illegal_c) begin
        cnt_d   = WIDTH'(home_state(mode_q));
        phase_d = '0;
      end else begin
        if (!dir_i) begin
          fb      = (mode_q == MODE_RING) ? cnt_o[WIDTH-1] : ~cnt_o[WIDTH-1];
          cnt_d   = {cnt_o[WIDTH-2:0], fb};
          phase_d = (phase_o == last) ? '0 : phase_o + PW'(1);
        end else begin
          fb      = (mode_q == MODE_RING) ? cnt_o[0] : ~cnt_o[0];
          cnt_d   = {fb, cnt_o[WIDTH-1:1]};
          phase_d = (phase_o == '0) ? last : phase_o - PW'(1);
        end
        // An empty ring would rotate zeros forever; seed a single one.
        if ((mode_q == MODE_RING) && (cnt_o == '0)) begin
          cnt_d = dir_i ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(1);
        end
        wrap_d = (phase_d == '0);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_o   <= '0;
      phase_o <= '0;
      wrap_o  <= 1'b0;
      mode_q  <= MODE_JOHNSON;
    end else begin
      cnt_o   <= cnt_d;
      phase_o <= phase_d;
      wrap_o  <= wrap_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_counter.sv
// Directed self-checking bench for shift_seq_counter at WIDTH=4.
module tb_shift_seq_counter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned PW    = $clog2(2 * WIDTH);

  logic             clk;
  logic             rst;
  logic             en_i;
  logic             dir_i;
  logic             mode_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] cnt_o;
  logic [PW-1:0]    phase_o;
  logic             wrap_o;

  int n_checks;
  int n_fail;

  shift_seq_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .cnt_o      (cnt_o),
    .phase_o    (phase_o),
    .wrap_o     (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic [2:0] p,
                           input logic w);
    check({tag, ".cnt"},   32'(cnt_o),   32'(c));
    check({tag, ".phase"}, 32'(phase_o), 32'(p));
    check({tag, ".wrap"},  32'(wrap_o),  32'(w));
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    load_i     = 1'b1;
    load_val_i = v;
    tick();
    load_i     = 1'b0;
  endtask

  logic [3:0] j_up [8];

  initial begin
    j_up = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    n_checks   = 0;
    n_fail     = 0;
    en_i       = 1'b0;
    dir_i      = 1'b0;
    mode_i     = 1'b0;
    load_i     = 1'b0;
    load_val_i = '0;
    rst        = 1'b0;
    #1 rst = 1'b1;
    #1 chk_state("reset", 4'b0000, 3'd0, 1'b0);
    #1 rst = 1'b0;

    // Johnson up from reset: full period, wrap only after the 8th step.
    en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_state($sformatf("jup%0d", i), j_up[i], 3'((i + 1) % 8), (i == 7));
    end

    // Hold: no step, wrap drops.
    en_i = 1'b0;
    tick();
    chk_state("hold", 4'b0000, 3'd0, 1'b0);

    // Mode change at 0111 with en_i high re-homes to ring.
    en_i = 1'b1;
    tick(); tick(); tick();
    chk_state("pre_mode", 4'b0111, 3'd3, 1'b0);
    mode_i = 1'b1;
    tick();
    chk_state("mode_chg", 4'b0001, 3'd0, 1'b0);
    tick();
    chk_state("ring_up", 4'b0010, 3'd1, 1'b0);

    // Ring down from home.
    en_i = 1'b0;
    load(4'b0001);
    en_i  = 1'b1;
    dir_i = 1'b1;
    tick(); chk_state("rdn0", 4'b1000, 3'd3, 1'b0);
    tick(); chk_state("rdn1", 4'b0100, 3'd2, 1'b0);
    tick(); chk_state("rdn2", 4'b0010, 3'd1, 1'b0);
    tick(); chk_state("rdn3", 4'b0001, 3'd0, 1'b1);

    // Empty ring seeds bit 0 on an up step.
    en_i = 1'b0;
    load(4'b0000);
    en_i  = 1'b1;
    dir_i = 1'b0;
    tick();
`ifdef SHIFT_SEQ_SELF_CORRECT_EN
    chk_state("ring_seed", 4'b0001, 3'd0, 1'b0);
`else
    chk_state("ring_seed", 4'b0001, 3'd1, 1'b0);
`endif

    // Back to Johnson.
    en_i   = 1'b0;
    mode_i = 1'b0;
    tick();
    chk_state("to_john", 4'b0000, 3'd0, 1'b0);

    // Load ignores en_i/dir_i; illegal Johnson state then stepped up.
    en_i  = 1'b1;
    dir_i = 1'b1;
    load(4'b0101);
    chk_state("load0101", 4'b0101, 3'd0, 1'b0);
    dir_i = 1'b0;
    tick();
`ifdef SHIFT_SEQ_SELF_CORRECT_EN
    chk_state("illegal", 4'b0000, 3'd0, 1'b0);
`else
    chk_state("illegal", 4'b1011, 3'd1, 1'b0);
`endif

    // Johnson down from home wraps phase 0 -> 7.
    load(4'b0000);
    dir_i = 1'b1;
    tick();
    chk_state("jdn", 4'b1000, 3'd7, 1'b0);

    // Count up to 1110 then reset between edges.
    load(4'b0000);
    dir_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_state("pre_rst", 4'b1110, 3'd5, 1'b0);
    #2 rst = 1'b1;
    #1 chk_state("async_rst", 4'b0000, 3'd0, 1'b0);
    #1 rst = 1'b0;

    // Load beats en_i in the same cycle.
    load_i     = 1'b1;
    load_val_i = 4'b1010;
    tick();
    load_i     = 1'b0;
    chk_state("load_win", 4'b1010, 3'd0, 1'b0);

    // Reset leaves mode_q in Johnson, so mode_i=1 re-homes to ring.
    en_i   = 1'b0;
    mode_i = 1'b1;
    tick();
    chk_state("post_rst_mode", 4'b0001, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
